// File: rtl/primogen_seek_if.sv
// Command/result handshake bundle for primogen_seek.
// master = command producer / result consumer, slave = the generator.
interface primogen_seek_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_seek;
  logic [WIDTH-1:0] cmd_seed;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res;
  logic             res_error;
  logic [CNT_W-1:0] table_count;

  modport master (
    output cmd_valid, cmd_seek, cmd_seed, res_ready,
    input  cmd_ready, res_valid, res, res_error, table_count
  );

  modport slave (
    input  cmd_valid, cmd_seek, cmd_seed, res_ready,
    output cmd_ready, res_valid, res, res_error, table_count
  );
endinterface

// File: rtl/primogen_seek.sv
// Prime generator: NEXT prime after the last result, or smallest prime >= a seed.
// Trial division by cached odd primes, then by odd divisors past the table.
module primogen_seek #(
  parameter int WIDTH       = 16,
  parameter int TABLE_DEPTH = 32,
  parameter int CNT_W       = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  primogen_seek_if.slave bus
);
  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam int BC_W  = $clog2(WIDTH);
  localparam int CW    = WIDTH + 1;
  localparam int SQ_W  = WIDTH + 3;

  typedef enum logic [2:0] {S_IDLE, S_CAND, S_TBL, S_DIV, S_FALL, S_DONE} state_e;

  function automatic logic [WIDTH-1:0] sat(input logic [SQ_W-1:0] v);
    return (|v[SQ_W-1:WIDTH]) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
  endfunction

  state_e                              state_q;
  logic                                cmd_ready_q, res_valid_q, res_err_q;
  logic [WIDTH-1:0]                    res_q, res_sq_q;
  logic [CNT_W-1:0]                    cnt_q, idx_q;
  logic                                contig_q, seek_q, from_fall_q;
  logic [WIDTH-1:0]                    seed_q, c_q, c_sq_q, d_q, d_sq_q;
  logic [WIDTH-1:0]                    den_q, num_q, rem_q;
  logic [BC_W-1:0]                     bcnt_q;
  logic [TABLE_DEPTH-1:0][WIDTH-1:0]   tbl_p_q, tbl_sq_q;

  // Candidate formation; squares are advanced incrementally from res^2.
  // The SEEK square is never used because SEEK disables appends.
  logic [CW-1:0]    cand_raw_d, cand_d, c_step_d;
  logic             cand_bump;
  logic [WIDTH-1:0] cand_sq_d, c_step_sq_d;

  assign cand_raw_d = seek_q ? ((seed_q < WIDTH'(2)) ? CW'(2) : CW'(seed_q))
                             : CW'(res_q) + CW'(1);
  assign cand_bump  = !(cand_raw_d == CW'(2) || cand_raw_d[0]);
  assign cand_d     = cand_bump ? cand_raw_d + CW'(1) : cand_raw_d;
  assign cand_sq_d  = seek_q    ? {WIDTH{1'b1}}
                    : cand_bump ? sat(SQ_W'(res_sq_q) + (SQ_W'(res_q) << 2) + SQ_W'(4))
                                : sat(SQ_W'(res_sq_q) + (SQ_W'(res_q) << 1) + SQ_W'(1));
  assign c_step_d    = CW'(c_q) + CW'(2);
  assign c_step_sq_d = sat(SQ_W'(c_sq_q) + (SQ_W'(c_q) << 2) + SQ_W'(4));

  // Table lookups
  logic [IDX_W-1:0] last_i;
  logic [WIDTH-1:0] ent_p, ent_sq, last_p, last_sq, d0_d, d0_sq_d, d_step_sq_d;
  logic             tbl_end;

  assign tbl_end     = (idx_q == cnt_q);
  assign ent_p       = tbl_p_q[idx_q[IDX_W-1:0]];
  assign ent_sq      = tbl_sq_q[idx_q[IDX_W-1:0]];
  assign last_i      = IDX_W'(cnt_q - 1'b1);
  assign last_p      = tbl_p_q[last_i];
  assign last_sq     = tbl_sq_q[last_i];
  assign d0_d        = (cnt_q == '0) ? WIDTH'(3) : last_p + WIDTH'(2);
  assign d0_sq_d     = (cnt_q == '0) ? WIDTH'(9)
                     : sat(SQ_W'(last_sq) + (SQ_W'(last_p) << 2) + SQ_W'(4));
  assign d_step_sq_d = sat(SQ_W'(d_sq_q) + (SQ_W'(d_q) << 2) + SQ_W'(4));

  // One restoring-remainder step per cycle
  logic [CW-1:0]    rem_sh;
  logic [WIDTH-1:0] rem_d;
  logic             div_last;

  assign rem_sh   = {rem_q, num_q[WIDTH-1]};
  assign rem_d    = (rem_sh >= CW'(den_q)) ? WIDTH'(rem_sh - CW'(den_q)) : rem_sh[WIDTH-1:0];
  assign div_last = (bcnt_q == BC_W'(WIDTH - 1));

  // Search termination, shared by every state that can reach DONE
  logic             fin, fin_err, append;
  logic [WIDTH-1:0] fin_c, fin_sq;

  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    fin_c   = c_q;
    fin_sq  = c_sq_q;
    unique case (state_q)
      S_CAND: begin
        fin_c  = cand_d[WIDTH-1:0];
        fin_sq = cand_sq_d;
        if (cand_d[WIDTH]) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (cand_d <= CW'(3)) begin
          fin = 1'b1;
        end
      end
      // p >= c also covers saturated squares near the top of the range
      S_TBL:  if (!tbl_end && (ent_sq > c_q || ent_p >= c_q)) fin = 1'b1;
      S_FALL: if (d_sq_q > c_q || d_q >= c_q) fin = 1'b1;
      S_DIV:  if (div_last && rem_d == '0 && c_step_d[WIDTH]) begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign append = fin && !fin_err && fin_c >= WIDTH'(3) && contig_q &&
                  cnt_q < CNT_W'(TABLE_DEPTH) && (cnt_q == '0 || fin_c > last_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_q       <= WIDTH'(1);
      res_sq_q    <= WIDTH'(1);
      cnt_q       <= '0;
      idx_q       <= '0;
      contig_q    <= 1'b1;
      seek_q      <= 1'b0;
      from_fall_q <= 1'b0;
      seed_q      <= '0;
      c_q         <= '0;
      c_sq_q      <= '0;
      d_q         <= '0;
      d_sq_q      <= '0;
      den_q       <= '0;
      num_q       <= '0;
      rem_q       <= '0;
      bcnt_q      <= '0;
      tbl_p_q     <= '0;
      tbl_sq_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.cmd_valid) begin
          seek_q      <= bus.cmd_seek;
          seed_q      <= bus.cmd_seed;
          res_err_q   <= 1'b0;
          cmd_ready_q <= 1'b0;
          state_q     <= S_CAND;
          if (bus.cmd_seek) contig_q <= 1'b0;
        end
        S_CAND: if (!fin) begin
          c_q     <= cand_d[WIDTH-1:0];
          c_sq_q  <= cand_sq_d;
          idx_q   <= '0;
          state_q <= S_TBL;
        end
        S_TBL: if (!fin) begin
          if (tbl_end) begin
            d_q     <= d0_d;
            d_sq_q  <= d0_sq_d;
            state_q <= S_FALL;
          end else begin
            den_q       <= ent_p;
            num_q       <= c_q;
            rem_q       <= '0;
            bcnt_q      <= '0;
            from_fall_q <= 1'b0;
            state_q     <= S_DIV;
          end
        end
        S_FALL: if (!fin) begin
          den_q       <= d_q;
          num_q       <= c_q;
          rem_q       <= '0;
          bcnt_q      <= '0;
          from_fall_q <= 1'b1;
          d_q         <= d_q + WIDTH'(2);
          d_sq_q      <= d_step_sq_d;
          state_q     <= S_DIV;
        end
        S_DIV: begin
          num_q  <= {num_q[WIDTH-2:0], 1'b0};
          rem_q  <= rem_d;
          bcnt_q <= bcnt_q + 1'b1;
          if (div_last) begin
            if (rem_d == '0) begin
              if (!c_step_d[WIDTH]) begin
                c_q     <= c_step_d[WIDTH-1:0];
                c_sq_q  <= c_step_sq_d;
                idx_q   <= '0;
                state_q <= S_TBL;
              end
            end else if (from_fall_q) begin
              state_q <= S_FALL;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_TBL;
            end
          end
        end
        S_DONE: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (fin) begin
        state_q     <= S_DONE;
        res_valid_q <= 1'b1;
        res_err_q   <= fin_err;
        if (!fin_err) begin
          res_q    <= fin_c;
          res_sq_q <= fin_sq;
        end
        if (append) begin
          tbl_p_q[cnt_q[IDX_W-1:0]]  <= fin_c;
          tbl_sq_q[cnt_q[IDX_W-1:0]] <= fin_sq;
          cnt_q                      <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res         = res_q;
  assign bus.res_error   = res_err_q;
  assign bus.table_count = cnt_q;
endmodule

// File: tb/tb_primogen_seek.sv
// Scoreboard bench: a 16-bit/32-entry instance and an 8-bit/4-entry instance
// checked against a plain trial-division reference model.
module tb_primogen_seek;
  typedef struct packed {
    logic [15:0] res;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [2];
  logic        cv [2], cs [2], rr [2];
  logic [15:0] sd [2];
  logic        crdy [2], rv [2], rerr [2];
  logic [15:0] rs [2];
  logic [7:0]  tc [2];

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q0[$], q1[$];
  int unsigned m_res [2], m_cnt [2], m_last [2];
  bit          m_contig [2];
  bit          last_err;

  primogen_seek_if #(.WIDTH(16), .CNT_W(6)) if16 ();
  primogen_seek_if #(.WIDTH(8),  .CNT_W(3)) if8 ();

  assign if16.cmd_valid = cv[0];
  assign if16.cmd_seek  = cs[0];
  assign if16.cmd_seed  = sd[0];
  assign if16.res_ready = rr[0];
  assign if8.cmd_valid  = cv[1];
  assign if8.cmd_seek   = cs[1];
  assign if8.cmd_seed   = sd[1][7:0];
  assign if8.res_ready  = rr[1];

  assign crdy[0] = if16.cmd_ready;
  assign rv[0]   = if16.res_valid;
  assign rs[0]   = if16.res;
  assign rerr[0] = if16.res_error;
  assign tc[0]   = {2'b0, if16.table_count};
  assign crdy[1] = if8.cmd_ready;
  assign rv[1]   = if8.res_valid;
  assign rs[1]   = {8'b0, if8.res};
  assign rerr[1] = if8.res_error;
  assign tc[1]   = {5'b0, if8.table_count};

  primogen_seek #(.WIDTH(16), .TABLE_DEPTH(32), .CNT_W(6)) u16 (
    .clk(clk), .rst_n(rstn[0]), .bus(if16));
  primogen_seek #(.WIDTH(8), .TABLE_DEPTH(4), .CNT_W(3)) u8 (
    .clk(clk), .rst_n(rstn[1]), .bus(if8));

  task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_prime(input int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void mreset(input int k);
    m_res[k] = 1; m_cnt[k] = 0; m_last[k] = 0; m_contig[k] = 1'b1;
  endfunction

  function automatic exp_t model_step(input int k, input bit seek, input int unsigned seed);
    int unsigned maxv  = (k == 0) ? 65535 : 255;
    int unsigned depth = (k == 0) ? 32 : 4;
    int unsigned p;
    exp_t e;
    if (seek) begin
      m_contig[k] = 1'b0;
      p = (seed < 2) ? 2 : seed;
    end else begin
      p = m_res[k] + 1;
    end
    while (p <= maxv && !is_prime(p)) p++;
    e.err = (p > maxv);
    if (!e.err) begin
      m_res[k] = p;
      if (p >= 3 && m_contig[k] && m_cnt[k] < depth && p > m_last[k]) begin
        m_cnt[k]++;
        m_last[k] = p;
      end
    end
    e.res = 16'(m_res[k]);
    e.cnt = 8'(m_cnt[k]);
    return e;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon16
    exp_t e;
    if (rv[0] && rr[0]) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut16_unexpected_result actual=%0d expected=none", rs[0]);
      end else begin
        e = q0.pop_front();
        chk("dut16_res", rs[0], e.res);
        chk("dut16_err", rerr[0], e.err);
        chk("dut16_cnt", tc[0], e.cnt);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rv[1] && rr[1]) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut8_unexpected_result actual=%0d expected=none", rs[1]);
      end else begin
        e = q1.pop_front();
        chk("dut8_res", rs[1], e.res);
        chk("dut8_err", rerr[1], e.err);
        chk("dut8_cnt", tc[1], e.cnt);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input int k, input bit seek, input int unsigned seed);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!crdy[k] && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (!crdy[k]) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_ready_timeout dut%0d actual=0 expected=1", k);
      return;
    end
    e = model_step(k, seek, seed);
    last_err = e.err;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
    cv[k] = 1'b1; cs[k] = seek; sd[k] = seed[15:0];
    @(posedge clk);
    #1 cv[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (((k == 0) ? q0.size() : q1.size()) != 0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    if (((k == 0) ? q0.size() : q1.size()) != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL result_timeout dut%0d actual=pending expected=drained", k);
      if (k == 0) q0.delete(); else q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int k, input bit seek, input int unsigned seed);
    issue(k, seek, seed);
    drain(k);
  endtask

  task automatic chk_reset(input int k);
    chk("rst_cmd_ready", crdy[k], 1);
    chk("rst_res_valid", rv[k], 0);
    chk("rst_res", rs[k], 1);
    chk("rst_res_error", rerr[k], 0);
    chk("rst_table_count", tc[k], 0);
  endtask

  initial begin
    rstn[0] = 1'b0; rstn[1] = 1'b0;
    cv[0] = 1'b0; cv[1] = 1'b0; cs[0] = 1'b0; cs[1] = 1'b0;
    sd[0] = '0; sd[1] = '0; rr[0] = 1'b1; rr[1] = 1'b1;
    mreset(0); mreset(1);
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // ---- 16-bit, 32-entry table ----
    for (int i = 0; i < 6; i++) run(0, 1'b0, 0);
    chk("t16_six_res", rs[0], 13);
    chk("t16_six_cnt", tc[0], 5);
    run(0, 1'b1, 0);  chk("t16_seek0", rs[0], 2);
    run(0, 1'b1, 1);  chk("t16_seek1", rs[0], 2);
    run(0, 1'b1, 90); chk("t16_seek90", rs[0], 97);
    run(0, 1'b1, 97); chk("t16_seek97", rs[0], 97);
    run(0, 1'b0, 0);  chk("t16_next101", rs[0], 101);
    chk("t16_no_append", tc[0], 5);

    // backpressure: result held, commands ignored while busy
    rr[0] = 1'b0;
    issue(0, 1'b0, 0);
    begin
      int n = 0;
      while (!rv[0] && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    chk("bp_valid_rose", rv[0], 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cv[0] = 1'b1; cs[0] = 1'b1; sd[0] = 16'd2;
      end else begin
        cv[0] = 1'b0;
      end
      chk("bp_valid", rv[0], 1);
      chk("bp_res", rs[0], 103);
      chk("bp_err", rerr[0], 0);
      chk("bp_cmd_ready", crdy[0], 0);
      @(negedge clk);
    end
    cv[0] = 1'b0;
    rr[0] = 1'b1;
    drain(0);
    repeat (30) @(negedge clk);
    chk("bp_pulse_dropped_valid", rv[0], 0);
    chk("bp_idle_ready", crdy[0], 1);

    // asynchronous reset in the middle of a division
    issue(0, 1'b1, 65521);
    repeat (10) @(posedge clk);
    #2 rstn[0] = 1'b0;
    #1 chk_reset(0);
    q0.delete();
    mreset(0);
    @(negedge clk);
    rstn[0] = 1'b1;
    run(0, 1'b0, 0); chk("rst_next2", rs[0], 2); chk("rst_no_cache2", tc[0], 0);
    run(0, 1'b0, 0); chk("rst_next3_cnt", tc[0], 1);

    for (int i = 0; i < 8; i++) begin
      bit sk = ($urandom_range(0, 3) != 0);
      run(0, sk, $urandom_range(0, 65535));
    end

    // ---- 8-bit, 4-entry table: walk every prime up to the range limit ----
    for (int i = 0; i < 60; i++) begin
      run(1, 1'b0, 0);
      if (rs[1] == 16'd127) chk("t8_cnt_at127", tc[1], 4);
      if (last_err) break;
    end
    chk("t8_top_res", rs[1], 251);
    chk("t8_top_err", rerr[1], 1);
    chk("t8_top_cnt", tc[1], 4);
    run(1, 1'b1, 252); chk("t8_seek252_err", rerr[1], 1); chk("t8_seek252_res", rs[1], 251);
    run(1, 1'b1, 251); chk("t8_seek251_err", rerr[1], 0);
    run(1, 1'b0, 0);   chk("t8_next_err", rerr[1], 1);
    run(1, 1'b1, 90);  chk("t8_seek90", rs[1], 97);
    for (int i = 0; i < 25; i++) begin
      bit sk = ($urandom_range(0, 2) != 0);
      run(1, sk, $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
